// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg: CSR addresses, mstatus bit indices, FSM state type, write-field masking helpers
package csr_regfile_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  typedef enum logic {RUN, REDIRECT} state_t;
  function automatic logic [31:0] csr_mask(input logic [11:0] a, input logic [31:0] d);
    return a == CSR_MSTATUS ? (32'h0000_1800 | (d & 32'h0000_0088)) :
           (a == CSR_MTVEC || a == CSR_MEPC) ? {d[31:2], 2'b00} : d;
  endfunction
  function automatic logic csr_writable(input logic [11:0] a);
    return a inside {CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
                     CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH};
  endfunction
endpackage

// File: rtl/csr_regfile_counter.sv
// csr_counter64: 64-bit counter (clk, rst_n, inc, wr_lo, wr_hi, wdata -> q); a half-write replaces that half and blocks the increment
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (wr_lo || wr_hi) q <= {wr_hi ? wdata : q[63:32], wr_lo ? wdata : q[31:0]};
    else if (inc) q <= q + 64'd1;
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: M-mode CSRs; comb read port (rd_addr -> rd_data/rd_illegal, write bypass), write-back port, trap/mret entry, mcycle/minstret, registered fetch redirect, mie out
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csrfin_rd_addr,
  output logic [31:0] csrfout_rd_data,
  output logic        csrfout_rd_illegal,
  input  logic        csrfin_wr_en,
  input  logic [11:0] csrfin_wr_addr,
  input  logic [31:0] csrfin_wr_data,
  input  logic        csrfin_trap_valid,
  input  logic [31:0] csrfin_trap_cause,
  input  logic [31:0] csrfin_trap_pc,
  input  logic [31:0] csrfin_trap_tval,
  input  logic        csrfin_mret_valid,
  input  logic        csrfin_instret,
  output logic        csrfout_redirect_valid,
  output logic [31:0] csrfout_redirect_pc,
  output logic        csrfout_mie
);
  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval, cur, wd;
  logic [63:0] mcycle, minstret;
  logic        wr_ok;
  state_t      state;
  assign wr_ok = csrfin_wr_en && !csrfin_trap_valid && !csrfin_mret_valid;
  assign wd = csr_mask(csrfin_wr_addr, csrfin_wr_data);
  assign csrfout_mie = mie;
  always_comb begin
    cur = '0;
    csrfout_rd_illegal = 1'b0;
    case (csrfin_rd_addr)
      CSR_MSTATUS:   cur = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
      CSR_MTVEC:     cur = mtvec;
      CSR_MSCRATCH:  cur = mscratch;
      CSR_MEPC:      cur = mepc;
      CSR_MCAUSE:    cur = mcause;
      CSR_MTVAL:     cur = mtval;
      CSR_MCYCLE:    cur = mcycle[31:0];
      CSR_MCYCLEH:   cur = mcycle[63:32];
      CSR_MINSTRET:  cur = minstret[31:0];
      CSR_MINSTRETH: cur = minstret[63:32];
      CSR_MHARTID:   cur = HART_ID;
      default:       csrfout_rd_illegal = 1'b1;
    endcase
  end
  assign csrfout_rd_data = (csrfin_wr_en && csrfin_wr_addr == csrfin_rd_addr && csr_writable(csrfin_rd_addr)) ?
                           csr_mask(csrfin_rd_addr, csrfin_wr_data) : cur;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mie <= 1'b0;
      mpie <= 1'b0;
      mtvec <= MTVEC_RESET;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
    end else if (csrfin_trap_valid) begin
      mepc <= {csrfin_trap_pc[31:2], 2'b00};
      mcause <= csrfin_trap_cause;
      mtval <= csrfin_trap_tval;
      mpie <= mie;
      mie <= 1'b0;
    end else if (csrfin_mret_valid) begin
      mie <= mpie;
      mpie <= 1'b1;
    end else if (wr_ok) begin
      case (csrfin_wr_addr)
        CSR_MSTATUS:  begin mie <= wd[MSTATUS_MIE]; mpie <= wd[MSTATUS_MPIE]; end
        CSR_MTVEC:    mtvec <= wd;
        CSR_MSCRATCH: mscratch <= wd;
        CSR_MEPC:     mepc <= wd;
        CSR_MCAUSE:   mcause <= wd;
        CSR_MTVAL:    mtval <= wd;
        default:      ;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      csrfout_redirect_valid <= 1'b0;
      csrfout_redirect_pc <= '0;
    end else if (csrfin_trap_valid || csrfin_mret_valid) begin
      state <= REDIRECT;
      csrfout_redirect_valid <= 1'b1;
      csrfout_redirect_pc <= csrfin_trap_valid ? mtvec : mepc;
    end else if (state == REDIRECT) begin
      state <= RUN;
      csrfout_redirect_valid <= 1'b0;
    end
  csr_counter64 u_mcycle (
    .clk(clk), .rst_n(rst_n), .inc(1'b1),
    .wr_lo(wr_ok && csrfin_wr_addr == CSR_MCYCLE),
    .wr_hi(wr_ok && csrfin_wr_addr == CSR_MCYCLEH),
    .wdata(csrfin_wr_data), .q(mcycle)
  );
  csr_counter64 u_minstret (
    .clk(clk), .rst_n(rst_n), .inc(csrfin_instret),
    .wr_lo(wr_ok && csrfin_wr_addr == CSR_MINSTRET),
    .wr_hi(wr_ok && csrfin_wr_addr == CSR_MINSTRETH),
    .wdata(csrfin_wr_data), .q(minstret)
  );
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed self-checking bench for csr_regfile
module tb_csr_regfile;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] rd_addr = '0, wr_addr = '0;
  logic [31:0] rd_data, wr_data = '0, trap_cause = '0, trap_pc = '0, trap_tval = '0, redirect_pc;
  logic        rd_illegal, wr_en = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0, instret = 1'b0;
  logic        redirect_valid, mie;
  int          pass_cnt = 0, total = 0;
  csr_regfile #(.MTVEC_RESET(32'h0000_0200), .HART_ID(32'h0000_0005)) dut (
    .clk(clk), .rst_n(rst_n),
    .csrfin_rd_addr(rd_addr), .csrfout_rd_data(rd_data), .csrfout_rd_illegal(rd_illegal),
    .csrfin_wr_en(wr_en), .csrfin_wr_addr(wr_addr), .csrfin_wr_data(wr_data),
    .csrfin_trap_valid(trap_valid), .csrfin_trap_cause(trap_cause), .csrfin_trap_pc(trap_pc),
    .csrfin_trap_tval(trap_tval), .csrfin_mret_valid(mret_valid), .csrfin_instret(instret),
    .csrfout_redirect_valid(redirect_valid), .csrfout_redirect_pc(redirect_pc), .csrfout_mie(mie)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [11:0] a);
    rd_addr = a;
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic test_reset;
    rd(12'h300);
    total++; if (rd_data !== 32'h0000_1800) $display("FAIL reset_mstatus got %h want %h", rd_data, 32'h0000_1800); else pass_cnt++;
    total++; if (rd_illegal !== 1'b0) $display("FAIL reset_mstatus_legal got %b want 0", rd_illegal); else pass_cnt++;
    rd(12'h305);
    total++; if (rd_data !== 32'h0000_0200) $display("FAIL reset_mtvec got %h want %h", rd_data, 32'h0000_0200); else pass_cnt++;
    rd(12'hF14);
    total++; if (rd_data !== 32'h0000_0005) $display("FAIL reset_mhartid got %h want %h", rd_data, 32'h0000_0005); else pass_cnt++;
    rd(12'h7C0);
    total++; if (rd_data !== 32'h0 || rd_illegal !== 1'b1) $display("FAIL reset_unimpl got %h/%b want 0/1", rd_data, rd_illegal); else pass_cnt++;
    total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || mie !== 1'b0) $display("FAIL reset_outputs got %b/%h/%b want 0/0/0", redirect_valid, redirect_pc, mie); else pass_cnt++;
  endtask
  task automatic test_write_bypass;
    wr_en = 1'b1;
    wr_addr = 12'h341;
    wr_data = 32'h8000_0107;
    rd(12'h341);
    total++; if (rd_data !== 32'h8000_0104) $display("FAIL bypass_mepc got %h want %h", rd_data, 32'h8000_0104); else pass_cnt++;
    tick();
    wr_en = 1'b0;
    rd(12'h341);
    total++; if (rd_data !== 32'h8000_0104) $display("FAIL readback_mepc got %h want %h", rd_data, 32'h8000_0104); else pass_cnt++;
    wr_en = 1'b1;
    wr_addr = 12'hF14;
    wr_data = 32'h0000_0099;
    rd(12'hF14);
    total++; if (rd_data !== 32'h0000_0005) $display("FAIL bypass_mhartid got %h want %h", rd_data, 32'h0000_0005); else pass_cnt++;
    tick();
    wr_en = 1'b0;
    rd(12'hF14);
    total++; if (rd_data !== 32'h0000_0005) $display("FAIL ro_mhartid got %h want %h", rd_data, 32'h0000_0005); else pass_cnt++;
    wr(12'h305, 32'h0000_0403);
    rd(12'h305);
    total++; if (rd_data !== 32'h0000_0400) $display("FAIL mtvec_mask got %h want %h", rd_data, 32'h0000_0400); else pass_cnt++;
  endtask
  task automatic test_trap;
    wr(12'h300, 32'h0000_0008);
    rd(12'h300);
    total++; if (rd_data !== 32'h0000_1808 || mie !== 1'b1) $display("FAIL set_mie got %h/%b want %h/1", rd_data, mie, 32'h0000_1808); else pass_cnt++;
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0103;
    trap_cause = 32'h2;
    trap_tval = 32'h0000_DEAD;
    wr_en = 1'b1;
    wr_addr = 12'h340;
    wr_data = 32'h0000_1234;
    tick();
    trap_valid = 1'b0;
    wr_en = 1'b0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0400) $display("FAIL trap_redirect got %b/%h want 1/%h", redirect_valid, redirect_pc, 32'h0000_0400); else pass_cnt++;
    rd(12'h341);
    total++; if (rd_data !== 32'h0000_0100) $display("FAIL trap_mepc got %h want %h", rd_data, 32'h0000_0100); else pass_cnt++;
    rd(12'h342);
    total++; if (rd_data !== 32'h2) $display("FAIL trap_mcause got %h want %h", rd_data, 32'h2); else pass_cnt++;
    rd(12'h343);
    total++; if (rd_data !== 32'h0000_DEAD) $display("FAIL trap_mtval got %h want %h", rd_data, 32'h0000_DEAD); else pass_cnt++;
    rd(12'h300);
    total++; if (rd_data !== 32'h0000_1880 || mie !== 1'b0) $display("FAIL trap_mstatus got %h/%b want %h/0", rd_data, mie, 32'h0000_1880); else pass_cnt++;
    rd(12'h340);
    total++; if (rd_data !== 32'h0) $display("FAIL trap_drops_write got %h want 0", rd_data); else pass_cnt++;
    tick();
    total++; if (redirect_valid !== 1'b0) $display("FAIL trap_redirect_drop got %b want 0", redirect_valid); else pass_cnt++;
  endtask
  task automatic test_mret;
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0100) $display("FAIL mret_redirect got %b/%h want 1/%h", redirect_valid, redirect_pc, 32'h0000_0100); else pass_cnt++;
    rd(12'h300);
    total++; if (rd_data !== 32'h0000_1888 || mie !== 1'b1) $display("FAIL mret_mstatus got %h/%b want %h/1", rd_data, mie, 32'h0000_1888); else pass_cnt++;
    tick();
    total++; if (redirect_valid !== 1'b0) $display("FAIL mret_redirect_drop got %b want 0", redirect_valid); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0200;
    trap_cause = 32'h8;
    tick();
    trap_valid = 1'b0;
    mret_valid = 1'b1;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0400) $display("FAIL b2b_trap got %b/%h want 1/%h", redirect_valid, redirect_pc, 32'h0000_0400); else pass_cnt++;
    tick();
    mret_valid = 1'b0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200) $display("FAIL b2b_mret got %b/%h want 1/%h", redirect_valid, redirect_pc, 32'h0000_0200); else pass_cnt++;
    rd(12'h300);
    total++; if (rd_data !== 32'h0000_1888) $display("FAIL b2b_mstatus got %h want %h", rd_data, 32'h0000_1888); else pass_cnt++;
    tick();
    total++; if (redirect_valid !== 1'b0) $display("FAIL b2b_drop got %b want 0", redirect_valid); else pass_cnt++;
  endtask
  task automatic test_mcycle;
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFE);
    rd(12'hB00);
    total++; if (rd_data !== 32'hFFFF_FFFE) $display("FAIL mcycle_write got %h want %h", rd_data, 32'hFFFF_FFFE); else pass_cnt++;
    tick();
    tick();
    rd(12'hB00);
    total++; if (rd_data !== 32'h0) $display("FAIL mcycle_wrap_lo got %h want 0", rd_data); else pass_cnt++;
    rd(12'hB80);
    total++; if (rd_data !== 32'h1) $display("FAIL mcycle_carry_hi got %h want 1", rd_data); else pass_cnt++;
  endtask
  task automatic test_minstret;
    rd(12'hB02);
    total++; if (rd_data !== 32'h0) $display("FAIL minstret_idle got %h want 0", rd_data); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      instret = 1'b1;
      tick();
      instret = 1'b0;
      tick();
    end
    rd(12'hB02);
    total++; if (rd_data !== 32'h5) $display("FAIL minstret_count got %h want 5", rd_data); else pass_cnt++;
    rd(12'hB82);
    total++; if (rd_data !== 32'h0) $display("FAIL minstreth got %h want 0", rd_data); else pass_cnt++;
    instret = 1'b1;
    wr(12'hB02, 32'h10);
    instret = 1'b0;
    rd(12'hB02);
    total++; if (rd_data !== 32'h10) $display("FAIL minstret_write_wins got %h want %h", rd_data, 32'h10); else pass_cnt++;
  endtask
  task automatic test_rst_mid;
    trap_valid = 1'b1;
    trap_pc = 32'h0000_0300;
    tick();
    total++; if (redirect_valid !== 1'b1) $display("FAIL rst_pre_redirect got %b want 1", redirect_valid); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) $display("FAIL rst_async_redirect got %b/%h want 0/0", redirect_valid, redirect_pc); else pass_cnt++;
    trap_valid = 1'b0;
    rd(12'h305);
    total++; if (rd_data !== 32'h0000_0200) $display("FAIL rst_mtvec got %h want %h", rd_data, 32'h0000_0200); else pass_cnt++;
    rd(12'h341);
    total++; if (rd_data !== 32'h0) $display("FAIL rst_mepc got %h want 0", rd_data); else pass_cnt++;
    rd(12'h300);
    total++; if (rd_data !== 32'h0000_1800 || mie !== 1'b0) $display("FAIL rst_mstatus got %h/%b want %h/0", rd_data, mie, 32'h0000_1800); else pass_cnt++;
    rd(12'hB80);
    total++; if (rd_data !== 32'h0) $display("FAIL rst_mcycleh got %h want 0", rd_data); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    #12;
    test_reset();
    #10 rst_n = 1'b1;
    tick();
    test_write_bypass();
    test_trap();
    test_mret();
    test_back_to_back();
    test_mcycle();
    test_minstret();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
